pattern_gen: RTL and testbench

Pixel-colour stage between the hsync/vsync timing counters and the LCD pins: consumes pixel coordinates, data-enable and sync signals, and drives registered RGB565 plus re-aligned sync/DE. It cycles through six test patterns, either automatically every N frames or on a button request. Pattern changes take effect only at frame boundaries, so frames never tear.

---
 rtl/pattern_pkg.sv | 49 ++++
 rtl/pattern_sequencer.sv | 94 +++++++++
 rtl/pattern_gen.sv | 110 +++++++++++
 tb/tb_pattern_gen.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_pkg.sv
// Shared pattern codes, RGB565 colour constants and default panel geometry
// for the LCD test-pattern generator.
package pattern_pkg;

   typedef enum logic [2:0] {
      PAT_SOLID      = 3'd0,
      PAT_BARS       = 3'd1,
      PAT_CHECKER    = 3'd2,
      PAT_GRADIENT   = 3'd3,
      PAT_MOVING_BAR = 3'd4,
      PAT_BORDER     = 3'd5
   } pattern_e;

   localparam pattern_e PAT_LAST = PAT_BORDER;

   localparam int H_ACTIVE_DEF = 480;
   localparam int V_ACTIVE_DEF = 272;

   // RGB565 packed as {r[4:0], g[5:0], b[4:0]}
   localparam logic [15:0] RGB_WHITE      = 16'hFFFF;
   localparam logic [15:0] RGB_YELLOW     = 16'hFFE0;
   localparam logic [15:0] RGB_CYAN       = 16'h07FF;
   localparam logic [15:0] RGB_GREEN      = 16'h07E0;
   localparam logic [15:0] RGB_MAGENTA    = 16'hF81F;
   localparam logic [15:0] RGB_RED        = 16'hF800;
   localparam logic [15:0] RGB_BLUE       = 16'h001F;
   localparam logic [15:0] RGB_BLACK      = 16'h0000;
   localparam logic [15:0] RGB_SOLID_BLUE = 16'h0010;

   function automatic logic [15:0] bar_colour(input logic [2:0] idx);
      logic [15:0] c;
      case (idx)
         3'd0:    c = RGB_WHITE;
         3'd1:    c = RGB_YELLOW;
         3'd2:    c = RGB_CYAN;
         3'd3:    c = RGB_GREEN;
         3'd4:    c = RGB_MAGENTA;
         3'd5:    c = RGB_RED;
         3'd6:    c = RGB_BLUE;
         default: c = RGB_BLACK;
      endcase
      return c;
   endfunction

   function automatic pattern_e next_pattern(input pattern_e p);
      return (p == PAT_LAST) ? PAT_SOLID : pattern_e'(p + 3'd1);
   endfunction

endpackage

// File: rtl/pattern_sequencer.sv
// Frame-rate state: button synchroniser, frame tick, auto-advance counter,
// pending request, current pattern and moving-bar position.
module pattern_sequencer
   import pattern_pkg::*;
#(
   parameter int H_ACTIVE           = H_ACTIVE_DEF,
   parameter int FRAMES_PER_PATTERN = 120
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_vsync,
   input  logic       i_next,
   output pattern_e   o_pattern,
   output logic [8:0] o_bar_pos
);

   localparam int CNT_W = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'((FRAMES_PER_PATTERN > 0) ? FRAMES_PER_PATTERN - 1 : 0);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             next_prev_q, next_prev_d;
   logic             vs_prev_q, vs_prev_d;
   logic             pending_q, pending_d;
   logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [8:0]       bar_pos_q, bar_pos_d;
   pattern_e         pattern_q, pattern_d;

   logic             next_edge;
   logic             frame_tick;
   logic             auto_due;
   logic             advance;
   logic [9:0]       bar_sum;

   always_comb begin
      sync1_d     = i_next;
      sync2_d     = sync1_q;
      next_prev_d = sync2_q;
      vs_prev_d   = i_vsync;
      pending_d   = pending_q;
      frame_cnt_d = frame_cnt_q;
      bar_pos_d   = bar_pos_q;
      pattern_d   = pattern_q;

      next_edge  = sync2_q & ~next_prev_q;
      frame_tick = vs_prev_q & ~i_vsync;
      auto_due   = (FRAMES_PER_PATTERN != 0) && (frame_cnt_q == CNT_LAST);
      advance    = frame_tick && (pending_q || auto_due);
      bar_sum    = {1'b0, bar_pos_q} + 10'd2;

      if (frame_tick) begin
         if (advance) begin
            pattern_d   = next_pattern(pattern_q);
            frame_cnt_d = '0;
            pending_d   = 1'b0;
         end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
         end
         bar_pos_d = (bar_sum >= 10'(H_ACTIVE)) ? 9'(bar_sum - 10'(H_ACTIVE)) : bar_sum[8:0];
      end

      // Applied after the clear so an edge landing on the tick is not lost
      if (next_edge) begin
         pending_d = 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         next_prev_q <= 1'b0;
         vs_prev_q   <= 1'b1;
         pending_q   <= 1'b0;
         frame_cnt_q <= '0;
         bar_pos_q   <= '0;
         pattern_q   <= PAT_SOLID;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         next_prev_q <= next_prev_d;
         vs_prev_q   <= vs_prev_d;
         pending_q   <= pending_d;
         frame_cnt_q <= frame_cnt_d;
         bar_pos_q   <= bar_pos_d;
         pattern_q   <= pattern_d;
      end
   end

   assign o_pattern = pattern_q;
   assign o_bar_pos = bar_pos_q;

endmodule

// File: rtl/pattern_gen.sv
// LCD test-pattern stage: per-pixel colour mux plus one output register that
// keeps RGB, DE and syncs aligned with a single cycle of latency.
module pattern_gen
   import pattern_pkg::*;
#(
   parameter int H_ACTIVE           = H_ACTIVE_DEF,
   parameter int V_ACTIVE           = V_ACTIVE_DEF,
   parameter int FRAMES_PER_PATTERN = 120,
   parameter int BAR_W              = 60
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [8:0] i_x,
   input  logic [8:0] i_y,
   input  logic       i_de,
   input  logic       i_hsync,
   input  logic       i_vsync,
   input  logic       i_next,
   output logic [4:0] o_r,
   output logic [5:0] o_g,
   output logic [4:0] o_b,
   output logic       o_de,
   output logic       o_hsync,
   output logic       o_vsync,
   output logic [2:0] o_pattern
);

   pattern_e    pattern;
   logic [8:0]  bar_pos;

   logic [15:0] rgb_q, rgb_d;
   logic        de_q, de_d;
   logic        hs_q, hs_d;
   logic        vs_q, vs_d;

   logic [2:0]  bar_idx;
   logic [9:0]  bar_end;
   logic [15:0] colour;

   pattern_sequencer #(
      .H_ACTIVE           (H_ACTIVE),
      .FRAMES_PER_PATTERN (FRAMES_PER_PATTERN)
   ) u_seq (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_vsync   (i_vsync),
      .i_next    (i_next),
      .o_pattern (pattern),
      .o_bar_pos (bar_pos)
   );

   always_comb begin
      // Comparator chain instead of a divide: last threshold passed wins
      bar_idx = '0;
      for (int k = 1; k < 8; k++) begin
         if (32'(i_x) >= 32'(k * BAR_W)) begin
            bar_idx = 3'(k);
         end
      end
      bar_end = {1'b0, bar_pos} + 10'd16;

      colour = RGB_BLACK;
      case (pattern)
         PAT_SOLID:    colour = RGB_SOLID_BLUE;
         PAT_BARS:     colour = bar_colour(bar_idx);
         PAT_CHECKER:  colour = (i_x[4] ^ i_y[4]) ? RGB_WHITE : RGB_BLACK;
         PAT_GRADIENT: colour = {i_x[8:4], i_x[8:3], 5'b0};
         PAT_MOVING_BAR: begin
            if ((i_x >= bar_pos) && ({1'b0, i_x} < bar_end)) begin
               colour = RGB_WHITE;
            end
         end
         PAT_BORDER: begin
            if ((i_x == 9'd0) || (i_x == 9'(H_ACTIVE - 1)) ||
                (i_y == 9'd0) || (i_y == 9'(V_ACTIVE - 1))) begin
               colour = RGB_WHITE;
            end
         end
         default:      colour = RGB_BLACK;
      endcase

      rgb_d = i_de ? colour : RGB_BLACK;
      de_d  = i_de;
      hs_d  = i_hsync;
      vs_d  = i_vsync;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rgb_q <= '0;
         de_q  <= 1'b0;
         hs_q  <= 1'b1;
         vs_q  <= 1'b1;
      end else begin
         rgb_q <= rgb_d;
         de_q  <= de_d;
         hs_q  <= hs_d;
         vs_q  <= vs_d;
      end
   end

   assign o_r       = rgb_q[15:11];
   assign o_g       = rgb_q[10:5];
   assign o_b       = rgb_q[4:0];
   assign o_de      = de_q;
   assign o_hsync   = hs_q;
   assign o_vsync   = vs_q;
   assign o_pattern = pattern;

endmodule

// File: tb/tb_pattern_gen.sv
// Directed bench for pattern_gen: one instance with auto-advance every 2
// frames, one with auto-advance off that is stepped by button pulses.
module tb_pattern_gen;

   localparam logic [15:0] WHITE      = 16'hFFFF;
   localparam logic [15:0] YELLOW     = 16'hFFE0;
   localparam logic [15:0] CYAN       = 16'h07FF;
   localparam logic [15:0] BLUE_FULL  = 16'h001F;
   localparam logic [15:0] BLACK      = 16'h0000;
   localparam logic [15:0] BLUE_SOLID = 16'h0010;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [8:0] x, y;
   logic       de, hsync, vsync, next_m;

   logic [4:0] r_m, b_m, r_a, b_a;
   logic [5:0] g_m, g_a;
   logic       de_m, hs_m, vs_m, de_a, hs_a, vs_a;
   logic [2:0] pat_m, pat_a;

   int          n_vec = 0;
   int          n_err = 0;
   int          exp_bar;
   logic [15:0] exp_q[$];
   logic [8:0]  gx;

   // clock / reset block
   always #5 clk = ~clk;

   pattern_gen #(.FRAMES_PER_PATTERN(2)) dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_x(x), .i_y(y), .i_de(de),
      .i_hsync(hsync), .i_vsync(vsync), .i_next(1'b0),
      .o_r(r_a), .o_g(g_a), .o_b(b_a), .o_de(de_a),
      .o_hsync(hs_a), .o_vsync(vs_a), .o_pattern(pat_a)
   );

   pattern_gen #(.FRAMES_PER_PATTERN(0)) dut_m (
      .i_clk(clk), .i_rst_n(rst_n), .i_x(x), .i_y(y), .i_de(de),
      .i_hsync(hsync), .i_vsync(vsync), .i_next(next_m),
      .o_r(r_m), .o_g(g_m), .o_b(b_m), .o_de(de_m),
      .o_hsync(hs_m), .o_vsync(vs_m), .o_pattern(pat_m)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
      end
   endtask

   // driver + scoreboard: expected colour queued at drive, popped one cycle later
   task automatic pix(input string tag, input int px, input int py, input logic pde,
                      input logic [15:0] exp_rgb);
      x  = 9'(px);
      y  = 9'(py);
      de = pde;
      exp_q.push_back(exp_rgb);
      step();
      chk(tag, 32'({r_m, g_m, b_m}), 32'(exp_q.pop_front()));
      chk({tag, "_de"}, 32'(de_m), 32'(pde));
      de = 1'b0;
   endtask

   task automatic bar_model_tick();
      exp_bar = exp_bar + 2;
      if (exp_bar >= 480) exp_bar = exp_bar - 480;
   endtask

   task automatic frame_tick();
      de    = 1'b0;
      vsync = 1'b0;
      step();
      bar_model_tick();
      vsync = 1'b1;
      step();
   endtask

   task automatic pulse_next();
      next_m = 1'b1;
      step();
      step();
      next_m = 1'b0;
      repeat (4) step();
   endtask

   task automatic advance_m();
      pulse_next();
      frame_tick();
   endtask

   initial begin
      rst_n = 1'b1; x = '0; y = '0; de = 1'b0;
      hsync = 1'b1; vsync = 1'b1; next_m = 1'b0; exp_bar = 0;
      #2 rst_n = 1'b0;
      repeat (3) step();
      chk("rst_rgb",   32'({r_m, g_m, b_m}), 32'(BLACK));
      chk("rst_de",    32'(de_m), 32'(0));
      chk("rst_hs",    32'(hs_m), 32'(1));
      chk("rst_vs",    32'(vs_m), 32'(1));
      chk("rst_pat_m", 32'(pat_m), 32'(0));
      chk("rst_pat_a", 32'(pat_a), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // auto-advance every 2 frames
      pix("blue_f0", 10, 10, 1'b1, BLUE_SOLID);
      chk("a_blue_f0", 32'({r_a, g_a, b_a}), 32'(BLUE_SOLID));
      frame_tick();
      chk("a_pat_t1", 32'(pat_a), 32'(0));
      pix("blue_f1", 20, 30, 1'b1, BLUE_SOLID);
      chk("a_blue_f1", 32'({r_a, g_a, b_a}), 32'(BLUE_SOLID));
      frame_tick();
      chk("a_pat_t2", 32'(pat_a), 32'(1));
      frame_tick();
      chk("a_pat_t3", 32'(pat_a), 32'(1));
      frame_tick();
      chk("a_pat_t4", 32'(pat_a), 32'(2));
      chk("m_no_auto", 32'(pat_m), 32'(0));

      // three pulses in one frame give a single advance
      pulse_next();
      pulse_next();
      pulse_next();
      chk("m_pend_wait", 32'(pat_m), 32'(0));
      frame_tick();
      chk("m_one_adv", 32'(pat_m), 32'(1));
      frame_tick();
      chk("m_no_extra", 32'(pat_m), 32'(1));

      pix("bar59",  59,  0, 1'b1, WHITE);
      pix("bar60",  60,  0, 1'b1, YELLOW);
      pix("bar120", 120, 3, 1'b1, CYAN);
      pix("bar419", 419, 3, 1'b1, BLUE_FULL);
      pix("bar420", 420, 3, 1'b1, BLACK);
      pix("bar479", 479, 3, 1'b1, BLACK);

      // edge coincident with the tick that consumes pending
      pulse_next();
      next_m = 1'b1;
      step();
      step();
      vsync = 1'b0;
      step();
      bar_model_tick();
      chk("m_coinc_adv", 32'(pat_m), 32'(2));
      next_m = 1'b0;
      vsync  = 1'b1;
      step();
      pix("chk_0_0",   0,  0, 1'b1, BLACK);
      pix("chk_16_0",  16, 0, 1'b1, WHITE);
      pix("chk_16_16", 16, 16, 1'b1, BLACK);
      pix("chk_5_20",  5,  20, 1'b1, WHITE);
      frame_tick();
      chk("m_kept_pend", 32'(pat_m), 32'(3));
      frame_tick();
      chk("m_pend_clr", 32'(pat_m), 32'(3));

      pix("grad_479", 479, 7, 1'b1, {5'd29, 6'd59, 5'd0});
      repeat (2) begin
         gx = 9'($urandom_range(0, 479));
         pix("grad_rand", int'(gx), 9, 1'b1, {gx[8:4], gx[8:3], 5'b0});
      end

      // moving bar over a full sweep of positions
      advance_m();
      chk("m_pat4", 32'(pat_m), 32'(4));
      for (int f = 0; f < 240; f++) begin
         frame_tick();
         pix("mbar_head", exp_bar, 100, 1'b1, WHITE);
         if (exp_bar + 16 < 480) pix("mbar_after", exp_bar + 16, 100, 1'b1, BLACK);
         if (exp_bar > 0) pix("mbar_before", exp_bar - 1, 100, 1'b1, BLACK);
         if (exp_bar == 472) begin
            for (int px = 472; px < 480; px++) pix("mbar_clip", px, 100, 1'b1, WHITE);
            pix("mbar_nowrap", 0, 100, 1'b1, BLACK);
         end
      end

      advance_m();
      chk("m_pat5", 32'(pat_m), 32'(5));
      pix("bord_0_100",   0,   100, 1'b1, WHITE);
      pix("bord_479_5",   479, 5,   1'b1, WHITE);
      pix("bord_240_271", 240, 271, 1'b1, WHITE);
      pix("bord_240_100", 240, 100, 1'b1, BLACK);
      pix("bord_de0",     0,   0,   1'b0, BLACK);

      hsync = 1'b0;
      step();
      chk("hs_delay_lo", 32'(hs_m), 32'(0));
      chk("vs_steady",   32'(vs_m), 32'(1));
      hsync = 1'b1;
      step();
      chk("hs_delay_hi", 32'(hs_m), 32'(1));
      vsync = 1'b0;
      step();
      bar_model_tick();
      chk("vs_delay_lo", 32'(vs_m), 32'(0));
      vsync = 1'b1;
      step();
      chk("vs_delay_hi", 32'(vs_m), 32'(1));
      chk("m_pat5_hold", 32'(pat_m), 32'(5));

      for (int i = 0; i < 4; i++) begin
         advance_m();
         chk("m_wrap_seq", 32'(pat_m), 32'(i));
      end

      // asynchronous reset in the middle of a gradient line
      pix("grad_200", 200, 50, 1'b1, {5'd12, 6'd25, 5'd0});
      x = 9'd300; de = 1'b1; hsync = 1'b0;
      step();
      chk("grad_300", 32'({r_m, g_m, b_m}), 32'({5'd18, 6'd37, 5'd0}));
      chk("hs_pre_rst", 32'(hs_m), 32'(0));
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_rgb", 32'({r_m, g_m, b_m}), 32'(BLACK));
      chk("mrst_de",  32'(de_m), 32'(0));
      chk("mrst_hs",  32'(hs_m), 32'(1));
      chk("mrst_vs",  32'(vs_m), 32'(1));
      chk("mrst_pat", 32'(pat_m), 32'(0));
      repeat (2) step();
      de = 1'b0; hsync = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      exp_bar = 0;

      pix("post_rst_blue", 10, 10, 1'b1, BLUE_SOLID);
      pulse_next();
      chk("no_spur_tick", 32'(pat_m), 32'(0));
      pix("post_rst_blue2", 11, 10, 1'b1, BLUE_SOLID);
      frame_tick();
      chk("post_rst_adv", 32'(pat_m), 32'(1));
      pix("post_rst_bars", 0, 0, 1'b1, WHITE);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
